morse_key_sequencer: RTL and testbench
======================================

// Module: morse_key_sequencer
// PURPOSE
//  Sits between ps2_controller and morse_code_encoder. Collects PS/2 make codes into a line buffer,
//  discards break/extended prefixes, supports Backspace/Escape editing, and on Enter plays the
//  buffered line to the encoder one scan code at a time over a valid/ready handshake.
// PARAMETERS
//  DEPTH       16     buffer entries (power of two, >= 2)
//  ENTER_CODE  8'h5A  starts playback
//  BREAK_CODE  8'hF0  break prefix; it and the next byte are discarded
//  EXT_CODE    8'hE0  extended prefix; discarded, the following byte is processed normally
//  ESC_CODE    8'h76  aborts playback / clears buffer
//  BKSP_CODE   8'h66  removes newest entry while collecting
// PORTS
//  clk                     in   1   system clock (50 MHz)
//  rst                     in   1   synchronous reset, active-low
//  ps2_received_data       in   8   byte from ps2_controller
//  ps2_received_data_strb  in   1   1-cycle strobe, byte valid
//  char_code               out  8   scan code presented to encoder
//  char_valid              out  1   char_code valid
//  char_ready              in   1   encoder idle, accepts char_code
//  busy                    out  1   high in PLAY
//  fill_level              out  $clog2(DEPTH+1)  entries held
//  overflow                out  1   1-cycle pulse: make code dropped, buffer full
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): state COLLECT, buffer empty, break flag clear; all outputs 0.
//  - Byte filter per strobe: EXT_CODE dropped; BREAK_CODE sets break flag, dropped; next byte with
//    break flag set is dropped and clears the flag. All other bytes are make codes.
//  - COLLECT: ordinary make code -> append (fill_level +1 next cycle); full -> drop, overflow pulse.
//    BKSP_CODE -> remove newest, no-op if empty. ESC_CODE -> clear buffer. ENTER_CODE with
//    fill_level>0 -> PLAY next cycle; empty -> ignored. Control codes are never stored.
//  - PLAY: play pointer starts at oldest entry; char_valid=1 and char_code=entry in the cycle after
//    the Enter strobe. char_code stable while char_valid && !char_ready. Transfer on
//    char_valid && char_ready; char_valid drops for exactly one cycle, then next entry presented.
//  - After last entry transfers: buffer emptied, state COLLECT, busy=0 next cycle.
//  - PLAY input: ESC_CODE -> abort: char_valid=0 next cycle, buffer cleared, COLLECT. A transfer in
//    the same cycle as the Esc strobe counts. Every other make code ignored (not stored, no overflow).
//  - Pointers are modulo DEPTH with wrap; full = fill_level==DEPTH, distinguished from empty by count.
//  - Simultaneous strobe and handshake handled independently in the same cycle.
//  - Reset mid-PLAY: immediate return to reset state, no further char_valid.
// CONFIGURATION
//  MORSE_LOOP_EN defined: after last entry, play pointer wraps to oldest entry and playback repeats
//    indefinitely; buffer preserved; exit only on ESC_CODE (clears) or ENTER_CODE (stops, keeps
//    buffer, COLLECT, appending resumes).
//  MORSE_LOOP_EN undefined: single pass as above; ENTER_CODE in PLAY ignored.
// STRUCTURE
//  Shared header morse_defs.vh: scan-code localparams (ENTER/BREAK/EXT/ESC/BKSP), state encodings
//    (COLLECT, PLAY), handshake width constants, reused by morse_code_encoder.
//  Sub-module scan_code_buffer: DEPTH x 8 storage, write/pop-newest/clear ports, independent
//    non-destructive read pointer with rewind; sequencer FSM and byte filter stay in top.
// TESTING
//  1C,32,21,5A with char_ready=1 -> char_code 1C,32,21 in order, one idle cycle between, then busy=0, fill 0.
//  1C,F0,1C,29,5A -> only 1C,29 played; byte after F0 never stored.
//  DEPTH+1 make codes -> fill_level=DEPTH, one overflow pulse; BKSP then 5A plays DEPTH-1 codes.
//  5A on empty buffer -> char_valid stays 0, busy 0; char_ready=0 held 100 cycles in PLAY -> code stable.
//  76 mid-PLAY -> char_valid 0 next cycle, fill 0; rst=0 mid-PLAY -> all outputs 0 next cycle.
//  MORSE_LOOP_EN: 1C,32,5A -> 1C,32,1C,32,...; 5A stops with fill_level=2.

Source files
------------

// File: rtl/morse_key_sequencer_pkg.sv
// Shared scan-code constants, code width and sequencer state encodings,
// also reused by morse_code_encoder.
package morse_key_sequencer_pkg;

  localparam int unsigned CODE_W = 8;

  localparam logic [CODE_W-1:0] KEY_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] KEY_BREAK = 8'hF0;
  localparam logic [CODE_W-1:0] KEY_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] KEY_ESC   = 8'h76;
  localparam logic [CODE_W-1:0] KEY_BKSP  = 8'h66;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PLAY    = 1'b1;

endpackage

// File: rtl/morse_key_sequencer_scan_code_buffer.sv
// DEPTH x CODE_W line buffer: append, pop-newest and clear on the write side,
// plus an independent non-destructive read pointer with rewind to the oldest entry.
module scan_code_buffer
  import morse_key_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [CODE_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         clear,
  input  logic                         rewind,
  input  logic                         advance,
  output logic [CODE_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     tail;
  logic [AW-1:0]     rd_ptr;

  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // Only the newest end moves and clear resets both ends, so the oldest
  // entry always sits at index 0; rewind therefore targets 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tail   <= '0;
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (clear) begin
        tail  <= '0;
        count <= '0;
      end else if (push && !full) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end else if (pop && (count != '0)) begin
        tail  <= tail - 1'b1;
        count <= count - 1'b1;
      end
      if (rewind)
        rd_ptr <= '0;
      else if (advance)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[tail] <= push_data;
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// PS/2 make-code line editor feeding morse_code_encoder over valid/ready.
// Define MORSE_LOOP_EN to repeat playback until Esc or Enter.
module morse_key_sequencer
  import morse_key_sequencer_pkg::*;
#(
  parameter int unsigned       DEPTH      = 16,
  parameter logic [CODE_W-1:0] ENTER_CODE = KEY_ENTER,
  parameter logic [CODE_W-1:0] BREAK_CODE = KEY_BREAK,
  parameter logic [CODE_W-1:0] EXT_CODE   = KEY_EXT,
  parameter logic [CODE_W-1:0] ESC_CODE   = KEY_ESC,
  parameter logic [CODE_W-1:0] BKSP_CODE  = KEY_BKSP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          ps2_received_data,
  input  logic                       ps2_received_data_strb,
  output logic [CODE_W-1:0]          char_code,
  output logic                       char_valid,
  input  logic                       char_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [0:0]        state;
  logic              break_flag;
  logic              valid_r;
  logic              overflow_r;
  logic [CW-1:0]     play_left;

  logic              make_strb, is_enter, is_esc, is_bksp, is_plain;
  logic              in_collect, xfer, last_xfer;
  logic              buf_push, buf_pop, buf_clear, buf_rewind;
  logic              buf_full;
  logic [CODE_W-1:0] rd_data;

  always_comb begin
    make_strb  = ps2_received_data_strb && !break_flag &&
                 (ps2_received_data != EXT_CODE) && (ps2_received_data != BREAK_CODE);
    is_enter   = make_strb && (ps2_received_data == ENTER_CODE);
    is_esc     = make_strb && (ps2_received_data == ESC_CODE);
    is_bksp    = make_strb && (ps2_received_data == BKSP_CODE);
    is_plain   = make_strb && !is_enter && !is_esc && !is_bksp;
    in_collect = (state == COLLECT);
    xfer       = valid_r && char_ready;
    last_xfer  = xfer && (play_left == CW'(1));
    buf_push   = in_collect && is_plain && !buf_full;
    buf_pop    = in_collect && is_bksp;
`ifdef MORSE_LOOP_EN
    buf_clear  = is_esc;
    buf_rewind = (in_collect && is_enter && (fill_level != '0)) || (!in_collect && last_xfer);
`else
    buf_clear  = is_esc || last_xfer;
    buf_rewind = in_collect && is_enter && (fill_level != '0);
`endif
  end

  scan_code_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (ps2_received_data),
    .pop       (buf_pop),
    .clear     (buf_clear),
    .rewind    (buf_rewind),
    .advance   (xfer),
    .rd_data   (rd_data),
    .count     (fill_level),
    .full      (buf_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= COLLECT;
      break_flag <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      play_left  <= '0;
    end else begin
      overflow_r <= in_collect && is_plain && buf_full;
      if (ps2_received_data_strb) begin
        if (break_flag)
          break_flag <= 1'b0;
        else if (ps2_received_data == BREAK_CODE)
          break_flag <= 1'b1;
      end
      if (in_collect) begin
        if (is_enter && (fill_level != '0)) begin
          state     <= PLAY;
          valid_r   <= 1'b1;
          play_left <= fill_level;
        end
      end else begin
        // Esc wins over a same-cycle transfer; the transfer itself still counts.
        if (is_esc) begin
          state   <= COLLECT;
          valid_r <= 1'b0;
`ifdef MORSE_LOOP_EN
        end else if (is_enter) begin
          state   <= COLLECT;
          valid_r <= 1'b0;
`endif
        end else if (xfer) begin
          valid_r <= 1'b0;
          if (play_left == CW'(1)) begin
`ifdef MORSE_LOOP_EN
            play_left <= fill_level;
`else
            state     <= COLLECT;
`endif
          end else begin
            play_left <= play_left - 1'b1;
          end
        end else if (!valid_r) begin
          valid_r <= 1'b1;
        end
      end
    end
  end

  assign char_valid = valid_r;
  assign char_code  = valid_r ? rd_data : '0;
  assign busy       = (state == PLAY);
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed self-checking bench for morse_key_sequencer (default DEPTH=16).
module tb_morse_key_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] char_code;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic [4:0] fill_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  morse_key_sequencer #(.DEPTH(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .char_code              (char_code),
    .char_valid             (char_valid),
    .char_ready             (char_ready),
    .busy                   (busy),
    .fill_level             (fill_level),
    .overflow               (overflow)
  );

  always #5 clk = ~clk;

  // One-cycle strobe; returns at the falling edge right after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    @(negedge clk);
    ps2_received_data_strb = 1'b0;
    ps2_received_data      = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b0; char_ready = 1'b0; ps2_received_data_strb = 1'b0; ps2_received_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({char_valid, busy, overflow, char_code, fill_level} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b b=%b o=%b code=%h fill=%0d exp all 0",
               char_valid, busy, overflow, char_code, fill_level);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] e [3] = '{8'h1C, 8'h32, 8'h21};
    char_ready = 1'b1;
    send(8'h1C); send(8'h32); send(8'h21);
    checks++;
    if (fill_level !== 5'd3) begin failures++; $display("FAIL basic_fill got=%0d exp=3", fill_level); end
    send(8'h5A);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (char_valid !== 1'b1 || char_code !== e[k] || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_code[%0d] got v=%b code=%h busy=%b exp v=1 code=%h busy=1", k, char_valid, char_code, busy, e[k]);
      end
      @(negedge clk);
      checks++;
      if (char_valid !== 1'b0) begin failures++; $display("FAIL basic_gap[%0d] got v=%b exp v=0", k, char_valid); end
      if (k < 2) @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || fill_level !== 5'd0) begin
      failures++; $display("FAIL basic_end got busy=%b fill=%0d exp busy=0 fill=0", busy, fill_level);
    end
  endtask

  task automatic test_break;
    char_ready = 1'b1;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE0); send(8'h29);
    checks++;
    if (fill_level !== 5'd2) begin failures++; $display("FAIL break_fill got=%0d exp=2", fill_level); end
    send(8'h5A);
    checks++;
    if (char_valid !== 1'b1 || char_code !== 8'h1C) begin
      failures++; $display("FAIL break_code0 got v=%b code=%h exp v=1 code=1c", char_valid, char_code);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (char_valid !== 1'b1 || char_code !== 8'h29) begin
      failures++; $display("FAIL break_code1 got v=%b code=%h exp v=1 code=29", char_valid, char_code);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fill_level !== 5'd0 || char_valid !== 1'b0) begin
      failures++; $display("FAIL break_end got busy=%b fill=%0d v=%b exp 0/0/0", busy, fill_level, char_valid);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] v;
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 8'h10 + 8'(i);
      send(v);
    end
    checks++;
    if (fill_level !== 5'd16 || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_full got fill=%0d ovf=%b exp fill=16 ovf=0", fill_level, overflow);
    end
    send(8'h40);
    checks++;
    if (overflow !== 1'b1 || fill_level !== 5'd16) begin
      failures++; $display("FAIL ovf_pulse got ovf=%b fill=%0d exp ovf=1 fill=16", overflow, fill_level);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_width got ovf=%b exp ovf=0", overflow); end
    send(8'h66);
    checks++;
    if (fill_level !== 5'd15) begin failures++; $display("FAIL ovf_bksp got fill=%0d exp=15", fill_level); end
    char_ready = 1'b1;
    send(8'h5A);
    for (int k = 0; k < 15; k++) begin
      v = 8'h10 + 8'(k);
      checks++;
      if (char_valid !== 1'b1 || char_code !== v) begin
        failures++; $display("FAIL ovf_play[%0d] got v=%b code=%h exp v=1 code=%h", k, char_valid, char_code, v);
      end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || fill_level !== 5'd0 || char_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_end got busy=%b fill=%0d v=%b exp 0/0/0", busy, fill_level, char_valid);
    end
  endtask

  task automatic test_enter_empty;
    char_ready = 1'b1;
    send(8'h5A);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (char_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL empty_enter[%0d] got v=%b busy=%b exp v=0 busy=0", i, char_valid, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    char_ready = 1'b0;
    send(8'h3B); send(8'h5A);
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (char_valid !== 1'b1 || char_code !== 8'h3B) begin
        failures++; $display("FAIL stall_hold[%0d] got v=%b code=%h exp v=1 code=3b", i, char_valid, char_code);
      end
      if (i == 50) send(8'h44);
      else @(negedge clk);
    end
    checks++;
    if (fill_level !== 5'd1 || overflow !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL stall_ignore got fill=%0d ovf=%b busy=%b exp fill=1 ovf=0 busy=1", fill_level, overflow, busy);
    end
    char_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (char_valid !== 1'b0 || busy !== 1'b0 || fill_level !== 5'd0) begin
      failures++; $display("FAIL stall_release got v=%b busy=%b fill=%0d exp 0/0/0", char_valid, busy, fill_level);
    end
  endtask

  task automatic test_esc;
    char_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h5A);
    checks++;
    if (char_valid !== 1'b1 || char_code !== 8'h1C) begin
      failures++; $display("FAIL esc_pre got v=%b code=%h exp v=1 code=1c", char_valid, char_code);
    end
    send(8'h76);
    checks++;
    if (char_valid !== 1'b0 || fill_level !== 5'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL esc_abort got v=%b fill=%0d busy=%b exp 0/0/0", char_valid, fill_level, busy);
    end
  endtask

  task automatic test_reset_mid_play;
    char_ready = 1'b0;
    send(8'h44); send(8'h5A);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstplay_pre got busy=%b exp=1", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({char_valid, busy, overflow, char_code, fill_level} !== 16'h0) begin
      failures++;
      $display("FAIL rstplay_outputs got v=%b b=%b o=%b code=%h fill=%0d exp all 0",
               char_valid, busy, overflow, char_code, fill_level);
    end
    rst = 1'b1;
    char_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (char_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstplay_after got v=%b busy=%b exp 0/0", char_valid, busy);
    end
  endtask

`ifdef MORSE_LOOP_EN
  task automatic test_loop;
    logic [7:0] e [2] = '{8'h1C, 8'h32};
    char_ready = 1'b1;
    send(8'h1C); send(8'h32); send(8'h5A);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (char_valid !== 1'b1 || char_code !== e[k % 2]) begin
        failures++; $display("FAIL loop_code[%0d] got v=%b code=%h exp v=1 code=%h", k, char_valid, char_code, e[k % 2]);
      end
      if (k == 5) char_ready = 1'b0;
      else repeat (2) @(negedge clk);
    end
    send(8'h5A);
    checks++;
    if (busy !== 1'b0 || char_valid !== 1'b0 || fill_level !== 5'd2) begin
      failures++; $display("FAIL loop_stop got busy=%b v=%b fill=%0d exp busy=0 v=0 fill=2", busy, char_valid, fill_level);
    end
    send(8'h76);
    checks++;
    if (fill_level !== 5'd0) begin failures++; $display("FAIL loop_clear got fill=%0d exp=0", fill_level); end
  endtask
`else
  task automatic test_enter_in_play;
    char_ready = 1'b0;
    send(8'h1C); send(8'h5A); send(8'h5A);
    checks++;
    if (char_valid !== 1'b1 || busy !== 1'b1 || fill_level !== 5'd1 || char_code !== 8'h1C) begin
      failures++; $display("FAIL play_enter got v=%b busy=%b fill=%0d code=%h exp 1/1/1/1c", char_valid, busy, fill_level, char_code);
    end
    char_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fill_level !== 5'd0) begin
      failures++; $display("FAIL play_enter_end got busy=%b fill=%0d exp 0/0", busy, fill_level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_overflow();
    test_enter_empty();
    test_stall();
    test_esc();
    test_reset_mid_play();
`ifdef MORSE_LOOP_EN
    test_loop();
`else
    test_enter_in_play();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
